// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and defaults for the fetch sequencer.
//   state_t : sequencer states (BOOT/FETCH/WAIT/HALT)
//   sel_t   : next-pc source select (increment, jump, interrupt entry, return)
//   PC_RST_VEC / PC_IRQ_VEC : default reset and interrupt entry addresses
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_INC  = 2'd0,
    SEL_JMP  = 2'd1,
    SEL_IRQ  = 2'd2,
    SEL_RETI = 2'd3
  } sel_t;

  localparam logic [15:0] PC_RST_VEC = 16'h0000;
  localparam logic [15:0] PC_IRQ_VEC = 16'h0008;

endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if: instruction-memory fetch port.
//   req  : fetch request, held stable until ack
//   addr : fetch address
//   ack  : memory accepted the request / instruction returned this cycle
// master = sequencer side, slave = memory side.
interface pc_seq_if #(
  parameter int AW = 16
);
  logic          req;
  logic [AW-1:0] addr;
  logic          ack;

  modport master (output req, output addr, input ack);
  modport slave  (input req, input addr, output ack);
endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-pc selection for pc_seq.
// Ports:
//   pc, epc       : current and saved-return program counter
//   in_isr        : interrupt service in progress
//   advance       : a fetch completed this cycle (fall-through is pc+1)
//   redir_ok      : redirects may be taken this cycle
//   jmp_req/addr  : jump request and target
//   irq, reti     : interrupt request, return-from-interrupt pulse
//   pc_next       : value to load into pc
//   seq_pc        : fall-through value (pc+1 or pc), also the interrupt return address
//   sel           : chosen source
//   take_jmp/irq  : one-cycle take indications
// Macro PC_SEQ_IRQ_EN enables the irq/reti sources; otherwise only jumps redirect.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int            AW      = 16,
  parameter logic [AW-1:0] IRQ_VEC = AW'(PC_IRQ_VEC)
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] epc,
  input  logic          in_isr,
  input  logic          advance,
  input  logic          redir_ok,
  input  logic          jmp_req,
  input  logic [AW-1:0] jmp_addr,
  input  logic          irq,
  input  logic          reti,
  output logic [AW-1:0] pc_next,
  output logic [AW-1:0] seq_pc,
  output sel_t          sel,
  output logic          take_jmp,
  output logic          take_irq
);

  // Wraps naturally at 2^AW.
  assign seq_pc = advance ? pc + AW'(1) : pc;

  always_comb begin
    sel = SEL_INC;
    if (redir_ok) begin
`ifdef PC_SEQ_IRQ_EN
      // reti outside an ISR is a no-op and must not mask lower sources.
      if (reti && in_isr)      sel = SEL_RETI;
      else if (irq && !in_isr) sel = SEL_IRQ;
      else if (jmp_req)        sel = SEL_JMP;
`else
      if (jmp_req) sel = SEL_JMP;
`endif
    end
  end

`ifndef PC_SEQ_IRQ_EN
  logic unused_irq_in;
  assign unused_irq_in = ^{irq, reti, in_isr};
`endif

  always_comb begin
    pc_next = seq_pc;
    case (sel)
      SEL_JMP:  pc_next = jmp_addr;
      SEL_IRQ:  pc_next = IRQ_VEC;
      SEL_RETI: pc_next = epc;
      default:  pc_next = seq_pc;
    endcase
  end

  assign take_jmp = (sel == SEL_JMP);
  assign take_irq = (sel == SEL_IRQ);

endmodule

// File: rtl/pc_seq.sv
// pc_seq: fetch sequencer, sole owner of the program counter.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   fbus (master)     : fetch req/addr out, ack in; addr always equals pc
//   pc                : current program counter
//   stall, halt       : levels, acted on when a fetch completes
//   jmp_req/jmp_addr  : level jump request and target; jmp_ack pulses when taken
//   irq, reti         : interrupt request and return pulse; irq_ack pulses when taken
//   epc               : saved return pc
// Macro PC_SEQ_IRQ_EN enables interrupt entry/return; without it irq_ack and epc stay 0.
//
// state | meaning
// BOOT  | first cycle after reset, no request
// FETCH | request outstanding at pc; pc frozen until ack
// WAIT  | stalled; redirects still load pc
// HALT  | idle until a redirect is taken
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int            AW      = 16,
  parameter logic [AW-1:0] RST_VEC = AW'(PC_RST_VEC),
  parameter logic [AW-1:0] IRQ_VEC = AW'(PC_IRQ_VEC)
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_seq_if.master      fbus,
  output logic [AW-1:0] pc,
  input  logic          stall,
  input  logic          halt,
  input  logic          jmp_req,
  input  logic [AW-1:0] jmp_addr,
  output logic          jmp_ack,
  input  logic          irq,
  input  logic          reti,
  output logic          irq_ack,
  output logic [AW-1:0] epc
);

  state_t        state, state_nx;
  logic [AW-1:0] pc_nx;
  logic [AW-1:0] seq_pc;
  sel_t          sel;
  logic          take_jmp, take_irq;
  logic          advance, redir_ok, redirect;
  logic          in_isr;

  // Under an outstanding request nothing may move the address.
  assign advance  = (state == ST_FETCH) && fbus.ack;
  assign redir_ok = advance || (state == ST_WAIT) || (state == ST_HALT);
  assign redirect = (sel != SEL_INC);

  pc_next_mux #(
    .AW      (AW),
    .IRQ_VEC (IRQ_VEC)
  ) u_next (
    .pc       (pc),
    .epc      (epc),
    .in_isr   (in_isr),
    .advance  (advance),
    .redir_ok (redir_ok),
    .jmp_req  (jmp_req),
    .jmp_addr (jmp_addr),
    .irq      (irq),
    .reti     (reti),
    .pc_next  (pc_nx),
    .seq_pc   (seq_pc),
    .sel      (sel),
    .take_jmp (take_jmp),
    .take_irq (take_irq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc    <= RST_VEC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  // A redirect only changes pc; halt/stall still decide the next state.
  always_comb begin
    state_nx = state;
    case (state)
      ST_BOOT:  state_nx = ST_FETCH;
      ST_FETCH: begin
        if (fbus.ack) begin
          if (halt)       state_nx = ST_HALT;
          else if (stall) state_nx = ST_WAIT;
          else            state_nx = ST_FETCH;
        end
      end
      ST_WAIT:  if (!stall) state_nx = halt ? ST_HALT : ST_FETCH;
      ST_HALT:  if (redirect) state_nx = ST_FETCH;
      default:  state_nx = ST_BOOT;
    endcase
  end

`ifdef PC_SEQ_IRQ_EN
  logic [AW-1:0] epc_q;

  // epc captures the fall-through pc, not a jump target competing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_isr <= 1'b0;
      epc_q  <= '0;
    end else if (sel == SEL_IRQ) begin
      in_isr <= 1'b1;
      epc_q  <= seq_pc;
    end else if (sel == SEL_RETI) begin
      in_isr <= 1'b0;
    end
  end

  assign epc = epc_q;
`else
  logic unused_seq_pc;
  assign in_isr        = 1'b0;
  assign epc           = '0;
  assign unused_seq_pc = ^seq_pc;
`endif

  assign fbus.req  = (state == ST_FETCH);
  assign fbus.addr = pc;
  assign jmp_ack   = take_jmp;
  assign irq_ack   = take_irq;

endmodule

// File: tb/tb_pc_seq.sv
module tb_pc_seq;

  localparam logic [15:0] IRQ_V = 16'h0008;
`ifdef PC_SEQ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  // Reference model modes
  localparam int M_BOOTING  = 0;
  localparam int M_FETCHING = 1;
  localparam int M_STALLED  = 2;
  localparam int M_HALTED   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, halt = 1'b0, jmp_req = 1'b0, irq = 1'b0, reti = 1'b0;
  logic [15:0] jmp_addr = '0;
  logic [15:0] pc, epc;
  logic        jmp_ack, irq_ack;

  pc_seq_if #(.AW(16)) fif ();

  pc_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fbus     (fif),
    .pc       (pc),
    .stall    (stall),
    .halt     (halt),
    .jmp_req  (jmp_req),
    .jmp_addr (jmp_addr),
    .jmp_ack  (jmp_ack),
    .irq      (irq),
    .reti     (reti),
    .irq_ack  (irq_ack),
    .epc      (epc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int          m_mode;
  logic [15:0] m_pc, m_epc;
  bit          m_isr;

  logic        s_req, s_jack, s_iack;
  logic [15:0] s_addr;

  typedef struct {
    bit          ack, stall, halt, jr;
    logic [15:0] ja;
    bit          x_req;
    logic [15:0] x_addr;
    bit          x_jack;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOTING;
    m_pc   = 16'h0000;
    m_epc  = 16'h0000;
    m_isr  = 1'b0;
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance model.
  task automatic cyc(input bit a, input bit s, input bit h, input bit jr,
                     input logic [15:0] ja, input bit i, input bit r);
    bit          fetched, pt, t_reti, t_irq, t_jmp;
    logic [15:0] fall, nxt;
    @(negedge clk);
    fif.ack = a; stall = s; halt = h; jmp_req = jr; jmp_addr = ja; irq = i; reti = r;
    #1;
    s_req = fif.req; s_addr = fif.addr; s_jack = jmp_ack; s_iack = irq_ack;
    chk("req", fif.req, 32'(m_mode == M_FETCHING));
    chk("addr", fif.addr, m_pc);
    chk("pc", pc, m_pc);
    chk("epc", epc, m_epc);
    fetched = (m_mode == M_FETCHING) && a;
    pt      = fetched || (m_mode == M_STALLED) || (m_mode == M_HALTED);
    fall    = fetched ? 16'(m_pc + 16'd1) : m_pc;
    t_reti  = IRQ_ON && pt && r && m_isr;
    t_irq   = IRQ_ON && pt && !t_reti && i && !m_isr;
    t_jmp   = pt && !t_reti && !t_irq && jr;
    chk("jmp_ack", jmp_ack, 32'(t_jmp));
    chk("irq_ack", irq_ack, 32'(t_irq));
    nxt = t_reti ? m_epc : t_irq ? IRQ_V : t_jmp ? ja : fall;
    case (m_mode)
      M_BOOTING:  m_mode = M_FETCHING;
      M_FETCHING: if (a) m_mode = h ? M_HALTED : (s ? M_STALLED : M_FETCHING);
      M_STALLED:  if (!s) m_mode = h ? M_HALTED : M_FETCHING;
      default:    if (t_reti || t_irq || t_jmp) m_mode = M_FETCHING;
    endcase
    if (t_irq) begin
      m_epc = fall;
      m_isr = 1'b1;
    end else if (t_reti) begin
      m_isr = 1'b0;
    end
    m_pc = nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ack, stall, halt, jr, ja, x_req, x_addr, x_jack
    tbl[0]  = '{0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0};
    tbl[1]  = '{1, 0, 0, 0, 16'h0000, 1, 16'h0000, 0};
    tbl[2]  = '{1, 0, 0, 0, 16'h0000, 1, 16'h0001, 0};
    tbl[3]  = '{1, 0, 0, 0, 16'h0000, 1, 16'h0002, 0};
    tbl[4]  = '{1, 0, 0, 0, 16'h0000, 1, 16'h0003, 0};
    tbl[5]  = '{0, 0, 0, 1, 16'h0200, 1, 16'h0004, 0};
    tbl[6]  = '{0, 0, 0, 1, 16'h0200, 1, 16'h0004, 0};
    tbl[7]  = '{1, 0, 0, 1, 16'h0200, 1, 16'h0004, 1};
    tbl[8]  = '{1, 1, 0, 0, 16'h0000, 1, 16'h0200, 0};
    tbl[9]  = '{0, 1, 0, 0, 16'h0000, 0, 16'h0201, 0};
    tbl[10] = '{0, 1, 0, 1, 16'h0300, 0, 16'h0201, 1};
    tbl[11] = '{0, 0, 0, 0, 16'h0000, 0, 16'h0300, 0};
    tbl[12] = '{1, 0, 1, 0, 16'h0000, 1, 16'h0300, 0};
    tbl[13] = '{0, 0, 0, 0, 16'h0000, 0, 16'h0301, 0};
    tbl[14] = '{0, 1, 1, 0, 16'h0000, 0, 16'h0301, 0};
    tbl[15] = '{0, 0, 0, 1, 16'h0100, 0, 16'h0301, 1};
    tbl[16] = '{0, 0, 0, 0, 16'h0000, 1, 16'h0100, 0};

    fif.ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", fif.req, 1'b0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_epc", epc, 16'h0000);
    chk("rst_jack", jmp_ack, 1'b0);
    chk("rst_iack", irq_ack, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    for (int k = 0; k < 17; k++) begin
      cyc(tbl[k].ack, tbl[k].stall, tbl[k].halt, tbl[k].jr, tbl[k].ja, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_req", k), s_req, tbl[k].x_req);
      chk($sformatf("tbl%0d_addr", k), s_addr, tbl[k].x_addr);
      chk($sformatf("tbl%0d_jack", k), s_jack, tbl[k].x_jack);
    end

    // pc wrap
    cyc(1, 0, 0, 1, 16'hFFFF, 0, 0);
    chk("jmp_ffff", fif.addr, 16'hFFFF);
    cyc(1, 0, 0, 0, 16'h0000, 0, 0);
    chk("wrap", fif.addr, 16'h0000);

    // jump held off while ack withheld
    cyc(1, 0, 0, 1, 16'h0010, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 1, 16'h0200, 0, 0);
      chk("hold_addr", s_addr, 16'h0010);
      chk("hold_jack", s_jack, 1'b0);
    end
    cyc(1, 0, 0, 1, 16'h0200, 0, 0);
    chk("hold_take", s_jack, 1'b1);
    chk("hold_tgt", fif.addr, 16'h0200);

    // stall then redirect in WAIT
    cyc(1, 0, 0, 1, 16'h0020, 0, 0);
    cyc(1, 1, 0, 0, 16'h0000, 0, 0);
    chk("wait_req", fif.req, 1'b0);
    chk("wait_pc", pc, 16'h0021);
    cyc(0, 1, 0, 1, 16'h0300, 0, 0);
    chk("wait_jmp", pc, 16'h0300);
    cyc(0, 0, 0, 0, 16'h0000, 0, 0);
    chk("wait_exit_req", fif.req, 1'b1);
    chk("wait_exit_addr", fif.addr, 16'h0300);

    // halt for 10 cycles, exit by jump
    cyc(1, 0, 0, 1, 16'h0040, 0, 0);
    cyc(1, 0, 1, 0, 16'h0000, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, k[0], 1, 0, 16'h0000, 0, 0);
      chk("halt_noreq", s_req, 1'b0);
    end
    cyc(0, 0, 0, 1, 16'h0100, 0, 0);
    chk("halt_exit_req", fif.req, 1'b1);
    chk("halt_exit_addr", fif.addr, 16'h0100);

    // irq against a competing jump
    cyc(1, 0, 0, 1, 16'h0050, 0, 0);
    cyc(1, 0, 0, 1, 16'h0300, 1, 0);
`ifdef PC_SEQ_IRQ_EN
    chk("irq_ack", s_iack, 1'b1);
    chk("irq_nojack", s_jack, 1'b0);
    chk("irq_vec", fif.addr, 16'h0008);
    chk("irq_epc", epc, 16'h0051);
`else
    chk("irq_ack_off", s_iack, 1'b0);
    chk("irq_jack_off", s_jack, 1'b1);
    chk("irq_jmp_off", fif.addr, 16'h0300);
    chk("irq_epc_off", epc, 16'h0000);
`endif
    cyc(1, 0, 0, 0, 16'h0000, 1, 0);
    chk("irq_nest", s_iack, 1'b0);
    cyc(1, 0, 0, 0, 16'h0000, 0, 1);
`ifdef PC_SEQ_IRQ_EN
    chk("reti_addr", fif.addr, 16'h0051);
`else
    chk("reti_addr_off", fif.addr, 16'h0302);
`endif
    cyc(1, 0, 0, 0, 16'h0000, 0, 1);
`ifdef PC_SEQ_IRQ_EN
    chk("reti_noop", fif.addr, 16'h0052);
`else
    chk("reti_noop_off", fif.addr, 16'h0303);
`endif

    // reset asserted under an outstanding request
    cyc(0, 0, 0, 0, 16'h0000, 0, 0);
    chk("pre_rst_req", s_req, 1'b1);
    @(negedge clk);
    fif.ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", fif.req, 1'b0);
    chk("midrst_pc", pc, 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // randomized traffic, jump requester holds jmp_req until acked
    begin
      bit          jp;
      logic [15:0] ja_r;
      bit          a, s, h, i, r;
      jp = 1'b0;
      ja_r = '0;
      for (int n = 0; n < 3000; n++) begin
        if (!jp && $urandom_range(0, 5) == 0) begin
          jp   = 1'b1;
          ja_r = 16'($urandom);
        end
        a = (m_mode == M_FETCHING) && ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 4) == 0);
        h = ($urandom_range(0, 15) == 0);
        i = ($urandom_range(0, 9) == 0);
        r = ($urandom_range(0, 7) == 0);
        cyc(a, s, h, jp, ja_r, i, r);
        if (s_jack) jp = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
